// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared definitions for the Sobel frame engine:
//   - sobel_state_e : frame sequencer states (IDLE, FETCH, DRAIN, DONE)
//   - GRAD_GUARD    : extra bits above PIX_W that hold the signed gradients
//                     and their magnitude without overflow (PIX_W+4 total)
//   - grad_width()  : gradient/magnitude width for a given pixel width
//   - sat_to_pix()  : clamp a magnitude to the largest pixel value
// -----------------------------------------------------------------------------
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sobel_state_e;

    // |Gx| and |Gy| are each at most 4*(2**PIX_W-1); their sum needs PIX_W+3
    // bits unsigned, and the signed gradients need PIX_W+3 bits, so PIX_W+4
    // leaves headroom for both.
    localparam int GRAD_GUARD = 4;

    // Widest pixel the saturation helper supports.
    localparam int MAX_PIX_W  = 16;
    localparam int MAX_GRAD_W = MAX_PIX_W + GRAD_GUARD;

    function automatic int grad_width(input int pix_w);
        grad_width = pix_w + GRAD_GUARD;
    endfunction

    // Clamp mag to 2**pix_w-1; the caller truncates the result to pix_w bits.
    function automatic logic [MAX_PIX_W-1:0] sat_to_pix(
        input logic [MAX_GRAD_W-1:0] mag,
        input int                    pix_w
    );
        logic [MAX_GRAD_W-1:0] limit;
        limit = (MAX_GRAD_W'(1) << pix_w) - MAX_GRAD_W'(1);
        if (mag > limit) begin
            sat_to_pix = MAX_PIX_W'(limit);
        end else begin
            sat_to_pix = MAX_PIX_W'(mag);
        end
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// -----------------------------------------------------------------------------
// sobel_line_buffer
// One image row of pixel storage: one write and one read per cycle, read data
// appears one cycle after rd_addr. Contents are not reset; the engine forces
// border pixels so stale entries never reach its output.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write column
//   wr_data  : pixel to store
//   rd_addr  : read column
//   rd_data  : pixel stored at rd_addr on the previous cycle
// -----------------------------------------------------------------------------
module sobel_line_buffer #(
    parameter  int DEPTH = 256,
    parameter  int WIDTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Row storage write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read port (one-cycle latency).
    always_ff @(posedge clk) begin
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sobel_frame_engine.sv
// -----------------------------------------------------------------------------
// sobel_frame_engine
// Reads one IMG_W x IMG_H frame from a source ROM in raster order, applies the
// 3x3 Sobel operator and writes one result pixel per cycle.
//
// Optional feature: define SOBEL_THRESH_EN to enable binary-threshold output
// (mode=1 writes all ones when |Gx|+|Gy| >= thr, else 0). Without the macro
// thr/mode are accepted but ignored and the output is always the saturated
// magnitude.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : one-cycle frame request (honoured only when idle)
//   thr, mode : threshold and output mode, captured when start is accepted
//   rd_addr   : ROM read address; rd_data returns one cycle later
//   wr_en, wr_addr, wr_data : result pixel write
//   busy      : frame in progress
//   done      : one-cycle pulse the cycle after the last write
//
// Pipeline: source index a is issued on rd_addr in cycle t, its pixel arrives
// in t+1 together with the two line-buffer pixels above it, forming the right
// column of the window whose centre is pixel a-IMG_W-1. That result is
// registered and written in t+2. The last IMG_W+1 results are all border
// pixels, so DRAIN issues IMG_W+1 dummy indices to keep the cadence going.
// -----------------------------------------------------------------------------
module sobel_frame_engine
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PIX_W-1:0]  thr,
    input  logic              mode,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int GW   = grad_width(PIX_W);
    localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DW   = $clog2(IMG_W + 2);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] FIRST_OUT = ADDR_W'(IMG_W + 1);
    localparam logic [XW-1:0]     X_LAST    = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(IMG_H - 1);
    localparam logic [DW-1:0]     DRAIN_END = DW'(IMG_W);

    // ------------------------------------------------------------------
    // Sequencer / read side
    // ------------------------------------------------------------------
    sobel_state_e      state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              start_accept_s;

    // Data-arrival stage
    logic              s1_valid_q, s1_valid_d;   // a result is computed this cycle
    logic              s1_fetch_q, s1_fetch_d;   // rd_data carries real pixel data
    logic [XW-1:0]     s1_x_q, s1_x_d;           // column of the arriving pixel

    // Output side
    logic [XW-1:0]     out_x_q, out_x_d;
    logic [YW-1:0]     out_y_q, out_y_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;

    // Window: columns 0 and 1 registered, column 2 live from rd_data/line buffers
    logic [PIX_W-1:0]  w00_q, w01_q, w10_q, w11_q, w20_q, w21_q;
    logic [PIX_W-1:0]  w00_d, w01_d, w10_d, w11_d, w20_d, w21_d;
    logic [PIX_W-1:0]  lb1_rdata_s, lb2_rdata_s;

    // Next-state and read-address sequencing.
    always_comb begin
        state_d        = state_q;
        rd_addr_d      = rd_addr_q;
        x_d            = x_q;
        y_d            = y_q;
        drain_cnt_d    = drain_cnt_q;
        s1_valid_d     = 1'b0;
        s1_fetch_d     = 1'b0;
        s1_x_d         = x_q;
        start_accept_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_accept_s = 1'b1;
                    state_d        = FETCH;
                    rd_addr_d      = {ADDR_W{1'b0}};
                    x_d            = {XW{1'b0}};
                    y_d            = {YW{1'b0}};
                    drain_cnt_d    = {DW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                s1_fetch_d = 1'b1;
                s1_valid_d = (rd_addr_q >= FIRST_OUT);
                if (rd_addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    if (x_q == X_LAST) begin
                        x_d = {XW{1'b0}};
                        if (y_q == Y_LAST) begin
                            y_d = y_q;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            DRAIN: begin
                // IMG_W+1 dummy issues, then wait for the last write to leave.
                if (drain_cnt_q <= DRAIN_END) begin
                    s1_valid_d  = 1'b1;
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end else begin
                    drain_cnt_d = drain_cnt_q;
                end
                if (wr_en_q && (wr_addr_q == LAST_ADDR)) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == FETCH) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    // ------------------------------------------------------------------
    // Captured configuration
    // ------------------------------------------------------------------
`ifdef SOBEL_THRESH_EN
    logic [PIX_W-1:0] thr_q, thr_d;
    logic             mode_q, mode_d;

    // Capture thr/mode when a frame is accepted.
    always_comb begin
        if (start_accept_s) begin
            thr_d  = thr;
            mode_d = mode;
        end else begin
            thr_d  = thr_q;
            mode_d = mode_q;
        end
    end

    // Configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_q  <= {PIX_W{1'b0}};
            mode_q <= 1'b0;
        end else begin
            thr_q  <= thr_d;
            mode_q <= mode_d;
        end
    end
`else
    logic unused_cfg_s;
    assign unused_cfg_s = ^{thr, mode};
`endif

    // ------------------------------------------------------------------
    // Line buffers: lb1 holds the row above the arriving pixel, lb2 two rows
    // above. Both are read at the issue column so the data lines up with
    // rd_data one cycle later, and written at the arrival column.
    // ------------------------------------------------------------------
    sobel_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_lb1 (
        .clk     (clk),
        .wr_en   (s1_fetch_q),
        .wr_addr (s1_x_q),
        .wr_data (rd_data),
        .rd_addr (x_q),
        .rd_data (lb1_rdata_s)
    );

    sobel_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_lb2 (
        .clk     (clk),
        .wr_en   (s1_fetch_q),
        .wr_addr (s1_x_q),
        .wr_data (lb1_rdata_s),
        .rd_addr (x_q),
        .rd_data (lb2_rdata_s)
    );

    // Shift the window left by one column on every real pixel arrival.
    always_comb begin
        if (s1_fetch_q) begin
            w00_d = w01_q;
            w01_d = lb2_rdata_s;
            w10_d = w11_q;
            w11_d = lb1_rdata_s;
            w20_d = w21_q;
            w21_d = rd_data;
        end else begin
            w00_d = w00_q;
            w01_d = w01_q;
            w10_d = w10_q;
            w11_d = w11_q;
            w20_d = w20_q;
            w21_d = w21_q;
        end
    end

    // ------------------------------------------------------------------
    // Gradient and output pixel
    // ------------------------------------------------------------------
    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        ext = $signed(GW'(p));
    endfunction

    logic signed [GW-1:0] gx_s, gy_s;
    logic [GW-1:0]        abs_gx_s, abs_gy_s, mag_s;
    logic                 border_s;
    logic [PIX_W-1:0]     pix_val_s;

    // Sobel gradients over the window; rows top to bottom, columns left to right.
    always_comb begin
        gx_s = (ext(lb2_rdata_s) + ext(lb1_rdata_s) + ext(lb1_rdata_s) + ext(rd_data))
             - (ext(w00_q) + ext(w10_q) + ext(w10_q) + ext(w20_q));
        gy_s = (ext(w20_q) + ext(w21_q) + ext(w21_q) + ext(rd_data))
             - (ext(w00_q) + ext(w01_q) + ext(w01_q) + ext(lb2_rdata_s));
        if (gx_s[GW-1]) begin
            abs_gx_s = $unsigned(-gx_s);
        end else begin
            abs_gx_s = $unsigned(gx_s);
        end
        if (gy_s[GW-1]) begin
            abs_gy_s = $unsigned(-gy_s);
        end else begin
            abs_gy_s = $unsigned(gy_s);
        end
        mag_s = abs_gx_s + abs_gy_s;
    end

    // Output value selection; borders are forced to zero in every mode.
    always_comb begin
        border_s = (out_x_q == {XW{1'b0}}) || (out_x_q == X_LAST) ||
                   (out_y_q == {YW{1'b0}}) || (out_y_q == Y_LAST);
        if (border_s) begin
            pix_val_s = {PIX_W{1'b0}};
        end
`ifdef SOBEL_THRESH_EN
        else if (mode_q) begin
            if (mag_s >= GW'(thr_q)) begin
                pix_val_s = {PIX_W{1'b1}};
            end else begin
                pix_val_s = {PIX_W{1'b0}};
            end
        end
`endif
        else begin
            pix_val_s = PIX_W'(sat_to_pix(MAX_GRAD_W'(mag_s), PIX_W));
        end
    end

    // Output coordinate tracking and write register.
    always_comb begin
        out_x_d    = out_x_q;
        out_y_d    = out_y_q;
        out_addr_d = out_addr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (start_accept_s) begin
            out_x_d    = {XW{1'b0}};
            out_y_d    = {YW{1'b0}};
            out_addr_d = {ADDR_W{1'b0}};
        end else if (s1_valid_q) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = out_addr_q;
            wr_data_d  = pix_val_s;
            out_addr_d = out_addr_q + ADDR_W'(1);
            if (out_x_q == X_LAST) begin
                out_x_d = {XW{1'b0}};
                if (out_y_q == Y_LAST) begin
                    out_y_d = out_y_q;
                end else begin
                    out_y_d = out_y_q + YW'(1);
                end
            end else begin
                out_x_d = out_x_q + XW'(1);
            end
        end else begin
            wr_en_d = 1'b0;
        end
    end

    // Control, pipeline and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_addr_q   <= {ADDR_W{1'b0}};
            x_q         <= {XW{1'b0}};
            y_q         <= {YW{1'b0}};
            drain_cnt_q <= {DW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_fetch_q  <= 1'b0;
            s1_x_q      <= {XW{1'b0}};
            out_x_q     <= {XW{1'b0}};
            out_y_q     <= {YW{1'b0}};
            out_addr_q  <= {ADDR_W{1'b0}};
            wr_en_q     <= 1'b0;
            wr_addr_q   <= {ADDR_W{1'b0}};
            wr_data_q   <= {PIX_W{1'b0}};
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            x_q         <= x_d;
            y_q         <= y_d;
            drain_cnt_q <= drain_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            s1_valid_q  <= s1_valid_d;
            s1_fetch_q  <= s1_fetch_d;
            s1_x_q      <= s1_x_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_addr_q  <= out_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Window column registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            w00_q <= {PIX_W{1'b0}};
            w01_q <= {PIX_W{1'b0}};
            w10_q <= {PIX_W{1'b0}};
            w11_q <= {PIX_W{1'b0}};
            w20_q <= {PIX_W{1'b0}};
            w21_q <= {PIX_W{1'b0}};
        end else begin
            w00_q <= w00_d;
            w01_q <= w01_d;
            w10_q <= w10_d;
            w11_q <= w11_d;
            w20_q <= w20_d;
            w21_q <= w21_d;
        end
    end

    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
